// File: rtl/neosd_pkg.sv
// neosd_pkg: shared types and constants for the NEOSD command engine.
// Build option: NEOSD_RSP_CRC_CHECK_EN enables the response CRC7 check.
package neosd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_TRAIL,
    ST_DONE
  } state_e;

  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int FRAME_LEN = 48;
  localparam int NCR_MAX_DEF = 64;
  localparam int TRAIL_CLKS_DEF = 8;

endpackage

// File: rtl/neosd_crc7.sv
// neosd_crc7: serial CRC7 (x^7+x^3+1), MSB first.
// clr_i restarts from zero; clr_i with en_i folds the first bit in.
module neosd_crc7
  import neosd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d, base;
  logic       fb;

  // next CRC value from the (optionally cleared) current one
  always_comb begin
    base  = clr_i ? 7'd0 : crc_q;
    fb    = bit_i ^ base[6];
    crc_d = base;
    if (en_i) crc_d = {base[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
  end

  // CRC register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) crc_q <= '0;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/neosd_cmd_engine.sv
// neosd_cmd_engine: SD clock, 48-bit command TX and response RX.
// Build option: NEOSD_RSP_CRC_CHECK_EN adds the response CRC7 check.
module neosd_cmd_engine
  import neosd_pkg::*;
#(
  parameter int NCR_MAX    = NCR_MAX_DEF,
  parameter int TRAIL_CLKS = TRAIL_CLKS_DEF
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [7:0]  clkgen_i,
  input  logic [2:0]  clksel_i,
  input  logic        start_i,
  input  logic [5:0]  cmd_idx_i,
  input  logic [31:0] cmd_arg_i,
  input  logic        rsp_en_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [5:0]  rsp_idx_o,
  output logic [31:0] rsp_arg_o,
  output logic        err_timeout_o,
  output logic        err_frame_o,
  output logic        err_crc_o,
  output logic        sd_clk_o,
  output logic        sd_cmd_o,
  output logic        sd_cmd_oe,
  input  logic        sd_cmd_i
);

  localparam int NW = $clog2(NCR_MAX + 1);
  localparam int TW = $clog2(TRAIL_CLKS + 1);

  state_e        state_q, state_d;
  logic [2:0]    clksel_q, clksel_d;
  logic          rsp_en_q, rsp_en_d;
  logic          sd_clk_q, sd_clk_d;
  logic          cmd_q, cmd_d, oe_q, oe_d;
  logic [38:0]   tx_sr_q, tx_sr_d;
  logic [5:0]    bit_q, bit_d, nb;
  logic [NW-1:0] ncr_q, ncr_d;
  logic [5:0]    rxc_q, rxc_d;
  logic [TW-1:0] trl_q, trl_d;
  logic [45:0]   rx_sr_q, rx_sr_d;
  logic [5:0]    rsp_idx_q, rsp_idx_d;
  logic [31:0]   rsp_arg_q, rsp_arg_d;
  logic          err_to_q, err_to_d, err_fr_q, err_fr_d;
  logic          tx_clr, tx_en, tx_bit;
  logic [6:0]    tx_crc;

  logic tick, act, rise, fall, accept;
  logic send_end, wait_hit, wait_to, recv_end, trail_end;

  assign tick      = clkgen_i[clksel_q];
  assign act       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign rise      = act && tick && !sd_clk_q;
  assign fall      = act && tick && sd_clk_q;
  assign accept    = (state_q == ST_IDLE) && start_i;
  assign send_end  = (state_q == ST_SEND) && fall && (bit_q == 6'd0);
  assign wait_hit  = (state_q == ST_WAIT) && rise && !sd_cmd_i;
  assign wait_to   = (state_q == ST_WAIT) && rise && sd_cmd_i
                     && (ncr_q == NW'(NCR_MAX - 1));
  assign recv_end  = (state_q == ST_RECV) && rise && (rxc_q == 6'd47);
  assign trail_end = (state_q == ST_TRAIL) && fall
                     && (trl_q == TW'(TRAIL_CLKS));

  neosd_crc7 u_tx_crc (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (tx_clr),
    .en_i   (tx_en),
    .bit_i  (tx_bit),
    .crc_o  (tx_crc)
  );

`ifdef NEOSD_RSP_CRC_CHECK_EN
  logic       rx_clr, rx_en, rx_bit;
  logic [6:0] rx_crc;
  logic       err_crc_q, err_crc_d;

  neosd_crc7 u_rx_crc (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (rx_clr),
    .en_i   (rx_en),
    .bit_i  (rx_bit),
    .crc_o  (rx_crc)
  );

  assign err_crc_o = err_crc_q;
`else
  assign err_crc_o = 1'b0;
`endif

  // state register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SEND;
      ST_SEND:  if (send_end) state_d = rsp_en_q ? ST_WAIT : ST_TRAIL;
      ST_WAIT: begin
        if (wait_hit)     state_d = ST_RECV;
        else if (wait_to) state_d = ST_TRAIL;
      end
      ST_RECV:  if (recv_end) state_d = ST_TRAIL;
      ST_TRAIL: if (trail_end) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // datapath and output next values
  always_comb begin
    clksel_d  = clksel_q;
    rsp_en_d  = rsp_en_q;
    sd_clk_d  = sd_clk_q;
    cmd_d     = cmd_q;
    oe_d      = oe_q;
    tx_sr_d   = tx_sr_q;
    bit_d     = bit_q;
    ncr_d     = ncr_q;
    rxc_d     = rxc_q;
    trl_d     = trl_q;
    rx_sr_d   = rx_sr_q;
    rsp_idx_d = rsp_idx_q;
    rsp_arg_d = rsp_arg_q;
    err_to_d  = err_to_q;
    err_fr_d  = err_fr_q;
    tx_clr    = 1'b0;
    tx_en     = 1'b0;
    tx_bit    = 1'b0;
`ifdef NEOSD_RSP_CRC_CHECK_EN
    err_crc_d = err_crc_q;
    rx_clr    = 1'b0;
    rx_en     = 1'b0;
    rx_bit    = 1'b0;
`endif
    nb = bit_q - 6'd1;
    if (act && tick) sd_clk_d = ~sd_clk_q;
    if (state_q == ST_DONE) sd_clk_d = 1'b0;

    if (accept) begin
      clksel_d = clksel_i;
      rsp_en_d = rsp_en_i;
      tx_sr_d  = {1'b1, cmd_idx_i, cmd_arg_i};
      bit_d    = 6'd47;
      cmd_d    = 1'b0;
      oe_d     = 1'b1;
      sd_clk_d = 1'b0;
      ncr_d    = '0;
      rxc_d    = '0;
      trl_d    = '0;
      err_to_d = 1'b0;
      err_fr_d = 1'b0;
      tx_clr   = 1'b1;
      tx_en    = 1'b1;
`ifdef NEOSD_RSP_CRC_CHECK_EN
      err_crc_d = 1'b0;
`endif
    end

    if (state_q == ST_SEND && fall) begin
      if (bit_q == 6'd0) begin
        oe_d  = 1'b0;
        cmd_d = 1'b1;
      end else begin
        bit_d = nb;
        if (nb >= 6'd8) begin
          cmd_d  = tx_sr_q[nb - 6'd8];
          tx_en  = 1'b1;
          tx_bit = tx_sr_q[nb - 6'd8];
        end else if (nb != 6'd0) begin
          cmd_d = tx_crc[3'(nb - 6'd1)];
        end else begin
          cmd_d = 1'b1;
        end
      end
    end

    if (state_q == ST_WAIT && rise) begin
      if (!sd_cmd_i) begin
        rxc_d = 6'd1;
`ifdef NEOSD_RSP_CRC_CHECK_EN
        rx_clr = 1'b1;
        rx_en  = 1'b1;
`endif
      end else begin
        ncr_d = ncr_q + NW'(1);
        if (wait_to) err_to_d = 1'b1;
      end
    end

    if (state_q == ST_RECV && rise) begin
      rx_sr_d = {rx_sr_q[44:0], sd_cmd_i};
      rxc_d   = rxc_q + 6'd1;
`ifdef NEOSD_RSP_CRC_CHECK_EN
      if (rxc_q <= 6'd39) begin
        rx_en  = 1'b1;
        rx_bit = sd_cmd_i;
      end
`endif
      if (recv_end) begin
        rsp_idx_d = rx_sr_q[44:39];
        rsp_arg_d = rx_sr_q[38:7];
        err_fr_d  = rx_sr_q[45] | ~sd_cmd_i;
`ifdef NEOSD_RSP_CRC_CHECK_EN
        err_crc_d = (rx_sr_q[6:0] != rx_crc);
`endif
      end
    end

    if (state_q == ST_TRAIL && rise) trl_d = trl_q + TW'(1);
  end

  // datapath registers
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      clksel_q  <= '0;
      rsp_en_q  <= 1'b0;
      sd_clk_q  <= 1'b0;
      cmd_q     <= 1'b1;
      oe_q      <= 1'b0;
      tx_sr_q   <= '0;
      bit_q     <= '0;
      ncr_q     <= '0;
      rxc_q     <= '0;
      trl_q     <= '0;
      rx_sr_q   <= '0;
      rsp_idx_q <= '0;
      rsp_arg_q <= '0;
      err_to_q  <= 1'b0;
      err_fr_q  <= 1'b0;
`ifdef NEOSD_RSP_CRC_CHECK_EN
      err_crc_q <= 1'b0;
`endif
    end else begin
      clksel_q  <= clksel_d;
      rsp_en_q  <= rsp_en_d;
      sd_clk_q  <= sd_clk_d;
      cmd_q     <= cmd_d;
      oe_q      <= oe_d;
      tx_sr_q   <= tx_sr_d;
      bit_q     <= bit_d;
      ncr_q     <= ncr_d;
      rxc_q     <= rxc_d;
      trl_q     <= trl_d;
      rx_sr_q   <= rx_sr_d;
      rsp_idx_q <= rsp_idx_d;
      rsp_arg_q <= rsp_arg_d;
      err_to_q  <= err_to_d;
      err_fr_q  <= err_fr_d;
`ifdef NEOSD_RSP_CRC_CHECK_EN
      err_crc_q <= err_crc_d;
`endif
    end
  end

  assign busy_o        = act;
  assign done_o        = (state_q == ST_DONE);
  assign rsp_idx_o     = rsp_idx_q;
  assign rsp_arg_o     = rsp_arg_q;
  assign err_timeout_o = err_to_q;
  assign err_frame_o   = err_fr_q;
  assign sd_clk_o      = sd_clk_q;
  assign sd_cmd_o      = cmd_q;
  assign sd_cmd_oe     = oe_q;

endmodule

// File: tb/tb_neosd_cmd_engine.sv
// tb_neosd_cmd_engine: directed transactions with an SD card model
// and an edge-level reference model of the CMD line.
module tb_neosd_cmd_engine;

  localparam int NCR = 64;
  localparam int TRL = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  clkgen;
  logic [2:0]  clksel_i;
  logic        start_i;
  logic [5:0]  cmd_idx_i;
  logic [31:0] cmd_arg_i;
  logic        rsp_en_i;
  logic        busy_o, done_o;
  logic [5:0]  rsp_idx_o;
  logic [31:0] rsp_arg_o;
  logic        err_timeout_o, err_frame_o, err_crc_o;
  logic        sd_clk_o, sd_cmd_o, sd_cmd_oe;
  logic        sd_cmd_i = 1'b1;

  int total = 0;
  int bad = 0;

  neosd_cmd_engine dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .clkgen_i      (clkgen),
    .clksel_i      (clksel_i),
    .start_i       (start_i),
    .cmd_idx_i     (cmd_idx_i),
    .cmd_arg_i     (cmd_arg_i),
    .rsp_en_i      (rsp_en_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .rsp_idx_o     (rsp_idx_o),
    .rsp_arg_o     (rsp_arg_o),
    .err_timeout_o (err_timeout_o),
    .err_frame_o   (err_frame_o),
    .err_crc_o     (err_crc_o),
    .sd_clk_o      (sd_clk_o),
    .sd_cmd_o      (sd_cmd_o),
    .sd_cmd_oe     (sd_cmd_oe),
    .sd_cmd_i      (sd_cmd_i)
  );

  always #5 clk = ~clk;

  // free-running prescaler: bit n pulses once every 2^(n+1) clocks
  logic [15:0] divc = '0;
  always @(posedge clk) divc <= divc + 16'd1;
  always_comb begin
    for (int n = 0; n < 8; n++)
      clkgen[n] = ((divc & ((16'd1 << (n + 1)) - 16'd1))
                   == ((16'd1 << (n + 1)) - 16'd1));
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] m_crc(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] ci,
                                           input logic [31:0] ca);
    logic [39:0] h;
    h = {2'b01, ci, ca};
    return {h, m_crc(h), 1'b1};
  endfunction

  // reference expectations for the current transaction
  logic [47:0] exp_frame, card_frame;
  logic [2:0]  exp_sel;
  logic        card_on, exp_to, exp_fr, exp_crc;
  logic [5:0]  exp_idx;
  logic [31:0] exp_arg;
  int          card_d, exp_total;
  logic        mon_on = 1'b0;
  logic        got_done;
  int          m_edge = 0;
  int          cyc = 0;
  int          last_rise = 0;
  logic        prev_sdclk = 1'b0;

  // compare process: each SD rising edge and each done pulse; card model
  always @(negedge clk) begin
    int nr, s;
    if (mon_on) begin
      if (sd_clk_o && !prev_sdclk) begin
        m_edge++;
        if (m_edge > 1)
          chk("sd_period", 64'(cyc - last_rise), 64'(1 << (exp_sel + 2)));
        last_rise = cyc;
        chk("busy_edge", busy_o, 1'b1);
        if (m_edge <= 48) begin
          chk("oe_send", sd_cmd_oe, 1'b1);
          chk($sformatf("cmd_bit%0d", 48 - m_edge), sd_cmd_o,
              exp_frame[48 - m_edge]);
        end else begin
          chk("oe_rel", sd_cmd_oe, 1'b0);
          chk("cmd_rel", sd_cmd_o, 1'b1);
        end
      end
      if (done_o) begin
        chk("done_once", got_done, 1'b0);
        got_done = 1'b1;
        chk("edges", 64'(m_edge), 64'(exp_total));
        chk("busy_done", busy_o, 1'b0);
        chk("sdclk_done", sd_clk_o, 1'b0);
        chk("oe_done", sd_cmd_oe, 1'b0);
        chk("err_to", err_timeout_o, exp_to);
        chk("err_fr", err_frame_o, exp_fr);
        chk("err_crc", err_crc_o, exp_crc);
        chk("rsp_idx", rsp_idx_o, exp_idx);
        chk("rsp_arg", rsp_arg_o, exp_arg);
      end
      nr = m_edge + 1;
      s  = 48 + card_d;
      if (card_on && nr >= s && nr <= s + 47)
        sd_cmd_i = card_frame[47 - (nr - s)];
      else
        sd_cmd_i = 1'b1;
    end else begin
      sd_cmd_i = 1'b1;
    end
    prev_sdclk = sd_clk_o;
    cyc++;
  end

  task automatic setup(input logic [5:0] ci, input logic [31:0] ca,
                       input logic re, input logic [2:0] sel,
                       input logic con, input int d,
                       input logic [47:0] cf);
    exp_frame  = mk_frame(ci, ca);
    exp_sel    = sel;
    card_on    = re && con;
    card_d     = d;
    card_frame = cf;
    exp_total  = 48 + TRL + (re ? (con ? d + 47 : NCR) : 0);
    exp_to     = re && !con;
    exp_fr     = 1'b0;
    exp_crc    = 1'b0;
    if (re && con) begin
      exp_idx = cf[45:40];
      exp_arg = cf[39:8];
      exp_fr  = cf[46] | ~cf[0];
`ifdef NEOSD_RSP_CRC_CHECK_EN
      exp_crc = (m_crc(cf[47:8]) != cf[7:1]);
`endif
    end
    m_edge   = 0;
    got_done = 1'b0;
    mon_on   = 1'b1;
    start_i   = 1'b1;
    cmd_idx_i = ci;
    cmd_arg_i = ca;
    rsp_en_i  = re;
    clksel_i  = sel;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_start", busy_o, 1'b1);
    chk("errs_clr", {err_timeout_o, err_frame_o, err_crc_o}, 3'b000);
  endtask

  task automatic run(input logic [5:0] ci, input logic [31:0] ca,
                     input logic re, input logic [2:0] sel,
                     input logic con, input int d,
                     input logic [47:0] cf);
    int n;
    setup(ci, ca, re, sel, con, d, cf);
    repeat (40) @(negedge clk);
    start_i   = 1'b1;
    cmd_idx_i = 6'h3F;
    cmd_arg_i = ~ca;
    rsp_en_i  = ~re;
    clksel_i  = sel + 3'd1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!got_done && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (!got_done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got=no_done want=done cmd=%0d", ci);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int dn, n;
    logic [39:0] h17;
    rstn      = 1'b0;
    start_i   = 1'b0;
    clksel_i  = 3'd0;
    cmd_idx_i = '0;
    cmd_arg_i = '0;
    rsp_en_i  = 1'b0;
    exp_idx   = '0;
    exp_arg   = '0;
    repeat (3) @(negedge clk);
    chk("rst_sdclk", sd_clk_o, 1'b0);
    chk("rst_cmd", sd_cmd_o, 1'b1);
    chk("rst_oe", sd_cmd_oe, 1'b0);
    chk("rst_busy_done", {busy_o, done_o}, 2'b00);
    chk("rst_rsp", {rsp_idx_o, rsp_arg_o}, 38'd0);
    chk("rst_errs", {err_timeout_o, err_frame_o, err_crc_o}, 3'b000);
    rstn = 1'b1;
    @(negedge clk);

    chk("pin_crc_cmd0", m_crc(40'h4000000000), 7'h4A);
    chk("pin_frame_cmd0", mk_frame(6'd0, 32'h0), 48'h400000000095);
    chk("pin_frame_cmd8", mk_frame(6'd8, 32'h1AA), 48'h48000001AA87);
    chk("pin_crc_r7", m_crc(40'h08000001AA), 7'h09);

    run(6'd0, 32'h0, 1'b0, 3'd0, 1'b0, 0, 48'h0);
    run(6'd8, 32'h1AA, 1'b1, 3'd1, 1'b1, 5, 48'h08000001AA13);
    chk("lit_idx8", rsp_idx_o, 6'd8);
    chk("lit_arg1aa", rsp_arg_o, 32'h1AA);
    chk("lit_noerr", {err_timeout_o, err_frame_o, err_crc_o}, 3'b000);
    run(6'd55, 32'h0, 1'b1, 3'd0, 1'b0, 0, 48'h0);
    chk("lit_timeout", err_timeout_o, 1'b1);
    chk("lit_rsp_hold", rsp_idx_o, 6'd8);
    run(6'd8, 32'h1AA, 1'b1, 3'd0, 1'b1, 5, 48'h08000001AA12);
    chk("lit_frame", err_frame_o, 1'b1);
    run(6'd8, 32'h1AA, 1'b1, 3'd0, 1'b1, 5, 48'h08000001AA15);
`ifdef NEOSD_RSP_CRC_CHECK_EN
    chk("lit_crc", err_crc_o, 1'b1);
`else
    chk("lit_crc", err_crc_o, 1'b0);
`endif

    setup(6'd17, 32'h1234, 1'b1, 3'd1, 1'b1, 3, 48'h0);
    n = 0;
    while (m_edge < 10 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_send_reached", 64'(m_edge >= 10), 64'd1);
    mon_on = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_sdclk", sd_clk_o, 1'b0);
    chk("abort_oe", sd_cmd_oe, 1'b0);
    chk("abort_busy_done", {busy_o, done_o}, 2'b00);
    rstn = 1'b1;
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_o) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    exp_idx = '0;
    exp_arg = '0;
    run(6'd0, 32'h0, 1'b0, 3'd2, 1'b0, 0, 48'h0);

    h17 = {2'b00, 6'd17, 32'h00000900};
    run(6'd17, 32'h0000_0800, 1'b1, 3'd1, 1'b1, 2,
        {h17, m_crc(h17), 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
